mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single 13-bit address / 8-bit bidirectional memory bus between two requesters:
//  port A (CPU fetch/load/store) and port B (debug/program loader).
//  Decodes the address into ROM (0x0000-0x0FFF) or RAM (0x1000-0x1FFF) and sequences the enable and strobe timing.
//  Returns read data and a one-cycle ACK to the granted requester. Sits between the CPU core and the ROM/RAM models.
// PARAMETERS
//  ADDR_W      13  address width; bit ADDR_W-1 selects RAM (1) or ROM (0)
//  DATA_W      8   data bus width
//  WAIT_CYCLES 1   cycles MEM_RD/MEM_WR held asserted (>=1)
// PORTS
//  CLK        in    1       single clock, rising edge
//  RST_N      in    1       asynchronous, active-low reset
//  A_REQ      in    1       port A request; held until A_ACK
//  A_WE       in    1       1=write, 0=read; stable while A_REQ
//  A_ADDR     in    ADDR_W  port A address; stable while A_REQ
//  A_WDATA    in    DATA_W  port A write data
//  A_GNT      out   1       port A owns bus (SETUP..DONE)
//  A_ACK      out   1       one-cycle completion pulse
//  B_*        -     -       identical set for port B
//  RDATA      out   DATA_W  read data, valid when A_ACK or B_ACK
//  ERR        out   1       with ACK: write to ROM region was rejected
//  ADDRESS    out   ADDR_W  memory address bus
//  DATA       inout DATA_W  memory data bus
//  ROM_EN     out   1       ROM chip enable
//  RAM_EN     out   1       RAM chip enable
//  MEM_RD     out   1       read strobe
//  MEM_WR     out   1       write strobe
// BEHAVIOUR
//  Reset (RST_N=0, async):
//   - All outputs 0; DATA=Z; state IDLE; round-robin pointer favours A.
//   - Reset mid-transaction aborts it and produces no ACK.
//  FSM: IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE -> IDLE.
//  IDLE:
//   - Arbitrate among REQs; register winner, address, WE and WDATA; go to SETUP.
//   - No REQ: stay in IDLE. All strobes and enables 0.
//  Arbitration: round-robin. If A_REQ and B_REQ are both high, the port not granted last wins.
//  First contest after reset goes to A.
//  SETUP: ADDRESS driven; ROM_EN=~ADDR[12], RAM_EN=ADDR[12]; GNT high; no strobe.
//  ACCESS:
//   - Read: MEM_RD=1.
//   - RAM write: MEM_WR=1 and DATA=WDATA.
//   - ROM write: no strobe, DATA stays Z; error flag set.
//   - RDATA sampled from DATA on the last ACCESS cycle.
//  DONE:
//   - Strobes 0; enables and ADDRESS held; granted port's ACK=1 for one cycle.
//   - ERR=1 only for a rejected ROM write. RDATA holds until the next read completes.
//  Latency: IDLE sample of REQ to ACK = 2+WAIT_CYCLES cycles; 3+WAIT_CYCLES between back-to-back grants.
//  DATA is driven only during RAM-write ACCESS cycles.
//  The IDLE cycle guarantees bus turnaround with no contention.
//  REQ dropped mid-transaction: transaction still completes and ACK still pulses.
//  A port must not reissue before seeing its ACK.
//  Address 0x0FFF is ROM; 0x1000 is RAM; 0x1FFF is RAM. No wrap behaviour.
// STRUCTURE
//  mem_bus_defs.vh holds:
//   - State encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3).
//   - ROM_BASE=13'h0000, RAM_BASE=13'h1000; the region-select bit index.
//  Sub-module rr_arbiter_2: inputs req[1:0], update, clk, rst_n; outputs one-hot gnt[1:0]; owns the priority pointer.
//  Top level contains the FSM, the wait counter (clog2(WAIT_CYCLES+1) bits), registered request fields and the tristate driver.
// TESTING
//  1. A reads 0x0021 with ROM model byte 0x01 -> ROM_EN=1, MEM_RD for 1 cycle, A_ACK at cycle 3, RDATA=0x01, ERR=0, DATA never driven by arbiter.
//  2. A writes 0x55 to 0x1002 -> RAM_EN=1, MEM_WR=1 with DATA=0x55 for 1 cycle; then B reads 0x1002 -> RDATA=0x55.
//  3. A_REQ and B_REQ high together, 4 reads each -> grants alternate A,B,A,B...; no ACK on an ungranted port.
//  4. B writes 0xAA to 0x0005 (ROM) -> no MEM_WR, DATA stays Z, B_ACK with ERR=1.
//  5. WAIT_CYCLES=3, A reads 0x1FFF -> MEM_RD high 3 cycles, A_ACK 5 cycles after request sampled.
//  6. RST_N pulsed low during ACCESS of an A write -> all outputs 0 and DATA=Z immediately; no A_ACK; next REQ served normally from IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-port memory bus arbiter: bus phase
// encoding, requester port indices and default widths.
package mem_bus_arbiter_pkg;

  // Bus phases of one transaction
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } bus_state_e;

  // Bit positions of the two requesters in req/gnt vectors
  localparam int unsigned PORT_A_IDX = 0;
  localparam int unsigned PORT_B_IDX = 1;

  // Address bit that selects RAM (1) or ROM (0) for the default map
  localparam int unsigned REGION_BIT = 12;

  localparam int unsigned DEF_ADDR_W      = REGION_BIT + 1;
  localparam int unsigned DEF_DATA_W      = 8;
  localparam int unsigned DEF_WAIT_CYCLES = 1;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin arbiter. Grant is combinational from the requests;
// the priority pointer advances only when the owner commits a grant.
module rr_arbiter_2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1: B holds priority on the next contest; 0: A does
  logic r_prio_b;

  // Resolve a contest with the pointer; a lone request always wins
  always_comb begin
    gnt = '0;
    if (req[PORT_A_IDX] && req[PORT_B_IDX]) begin
      if (r_prio_b) gnt[PORT_B_IDX] = 1'b1;
      else          gnt[PORT_A_IDX] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  // Hand priority to the port that did not just win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_b <= 1'b0;
    end else if (update && (gnt != '0)) begin
      r_prio_b <= gnt[PORT_A_IDX];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one address/data memory bus between port A (CPU) and port B
// (debug/loader). Decodes ROM/RAM by the top address bit, sequences the
// enable/strobe phases and returns read data with a one-cycle ACK.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_WDATA,
  output logic              A_GNT,
  output logic              A_ACK,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_GNT,
  output logic              B_ACK,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic [ADDR_W-1:0] ADDRESS,
  inout  wire logic [DATA_W-1:0] DATA,
  output logic              ROM_EN,
  output logic              RAM_EN,
  output logic              MEM_RD,
  output logic              MEM_WR
);

  localparam int unsigned MSB   = ADDR_W - 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

  bus_state_e        r_state;
  logic              r_sel_b;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_wait;
  logic              r_rom_wr;

  logic              r_a_gnt;
  logic              r_b_gnt;
  logic              r_a_ack;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [ADDR_W-1:0] r_address;
  logic              r_rom_en;
  logic              r_ram_en;
  logic              r_mem_rd;
  logic              r_mem_wr;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_update;
  logic              w_sel_b;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_we;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_req[PORT_A_IDX] = A_REQ;
  assign w_req[PORT_B_IDX] = B_REQ;
  assign w_update          = (r_state == ST_IDLE) && (w_req != '0);

  rr_arbiter_2 u_rr (
    .clk    (CLK),
    .rst_n  (RST_N),
    .req    (w_req),
    .update (w_update),
    .gnt    (w_gnt)
  );

  assign w_sel_b     = w_gnt[PORT_B_IDX];
  assign w_sel_addr  = w_sel_b ? B_ADDR  : A_ADDR;
  assign w_sel_we    = w_sel_b ? B_WE    : A_WE;
  assign w_sel_wdata = w_sel_b ? B_WDATA : A_WDATA;

  // The write strobe and the data driver share one register, so the bus is
  // only ever driven while a RAM write strobe is on the wire.
  assign DATA = r_mem_wr ? r_wdata : 'z;

  assign A_GNT   = r_a_gnt;
  assign B_GNT   = r_b_gnt;
  assign A_ACK   = r_a_ack;
  assign B_ACK   = r_b_ack;
  assign RDATA   = r_rdata;
  assign ERR     = r_err;
  assign ADDRESS = r_address;
  assign ROM_EN  = r_rom_en;
  assign RAM_EN  = r_ram_en;
  assign MEM_RD  = r_mem_rd;
  assign MEM_WR  = r_mem_wr;

  // Transaction sequencer; every bus output is registered with the phase it belongs to
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_sel_b   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wait    <= '0;
      r_rom_wr  <= 1'b0;
      r_a_gnt   <= 1'b0;
      r_b_gnt   <= 1'b0;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_address <= '0;
      r_rom_en  <= 1'b0;
      r_ram_en  <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req != '0) begin
            r_sel_b   <= w_sel_b;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_address <= w_sel_addr;
            r_rom_en  <= ~w_sel_addr[MSB];
            r_ram_en  <= w_sel_addr[MSB];
            r_a_gnt   <= ~w_sel_b;
            r_b_gnt   <= w_sel_b;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_wait   <= CNT_W'(1);
          r_mem_rd <= ~r_we;
          r_mem_wr <= r_we & r_addr[MSB];
          r_rom_wr <= r_we & ~r_addr[MSB];
          r_state  <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (r_wait == WAIT_LAST) begin
            if (!r_we) r_rdata <= DATA;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_a_ack  <= ~r_sel_b;
            r_b_ack  <= r_sel_b;
            r_err    <= r_rom_wr;
            r_state  <= ST_DONE;
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_a_ack   <= 1'b0;
          r_b_ack   <= 1'b0;
          r_err     <= 1'b0;
          r_rom_wr  <= 1'b0;
          r_a_gnt   <= 1'b0;
          r_b_gnt   <= 1'b0;
          r_rom_en  <= 1'b0;
          r_ram_en  <= 1'b0;
          r_address <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random
// two-port traffic against a transaction-level timing and memory model.
module tb_mem_bus_arbiter;

  localparam int WC = 1;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        A_REQ, A_WE, B_REQ, B_WE;
  logic [12:0] A_ADDR, B_ADDR;
  logic [7:0]  A_WDATA, B_WDATA;
  logic        A_GNT, A_ACK, B_GNT, B_ACK, ERR, ROM_EN, RAM_EN, MEM_RD, MEM_WR;
  logic [7:0]  RDATA;
  logic [12:0] ADDRESS;
  wire  [7:0]  DATA;

  logic        A_REQ3, A_WE3, B_REQ3, B_WE3;
  logic [12:0] A_ADDR3, B_ADDR3;
  logic [7:0]  A_WDATA3, B_WDATA3;
  logic        A_GNT3, A_ACK3, B_GNT3, B_ACK3, ERR3, ROM_EN3, RAM_EN3, MEM_RD3, MEM_WR3;
  logic [7:0]  RDATA3;
  logic [12:0] ADDRESS3;
  wire  [7:0]  DATA3;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_bus_arbiter u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA), .A_GNT(A_GNT), .A_ACK(A_ACK),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_GNT(B_GNT), .B_ACK(B_ACK),
    .RDATA(RDATA), .ERR(ERR), .ADDRESS(ADDRESS), .DATA(DATA),
    .ROM_EN(ROM_EN), .RAM_EN(RAM_EN), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ(A_REQ3), .A_WE(A_WE3), .A_ADDR(A_ADDR3), .A_WDATA(A_WDATA3), .A_GNT(A_GNT3), .A_ACK(A_ACK3),
    .B_REQ(B_REQ3), .B_WE(B_WE3), .B_ADDR(B_ADDR3), .B_WDATA(B_WDATA3), .B_GNT(B_GNT3), .B_ACK(B_ACK3),
    .RDATA(RDATA3), .ERR(ERR3), .ADDRESS(ADDRESS3), .DATA(DATA3),
    .ROM_EN(ROM_EN3), .RAM_EN(RAM_EN3), .MEM_RD(MEM_RD3), .MEM_WR(MEM_WR3)
  );

  // Fixed contents of the memory devices before any write
  function automatic logic [7:0] rom_byte(input logic [12:0] a);
    return a[7:0] - 8'h20;
  endfunction

  function automatic logic [7:0] ram_init(input logic [12:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  // Memory devices on the bus (environment, not the reference)
  logic [7:0] dev_ram [4096];
  bit         dev_wv  [4096];
  logic [7:0] dev_rd;

  always @(posedge CLK) begin
    if (MEM_WR && RAM_EN) begin
      dev_ram[ADDRESS[11:0]] <= DATA;
      dev_wv[ADDRESS[11:0]]  <= 1'b1;
    end
  end

  always_comb begin
    dev_rd = 8'h00;
    if (ADDRESS[12]) dev_rd = dev_wv[ADDRESS[11:0]] ? dev_ram[ADDRESS[11:0]] : ram_init(ADDRESS);
    else             dev_rd = rom_byte(ADDRESS);
  end

  assign DATA  = (MEM_RD && (ROM_EN || RAM_EN)) ? dev_rd : 8'hzz;
  assign DATA3 = MEM_RD3 ? (ADDRESS3[12] ? ram_init(ADDRESS3) : rom_byte(ADDRESS3)) : 8'hzz;

  // Reference model state
  logic [7:0] ref_ram [4096];
  bit         last_a;
  logic [7:0] hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] pick_addr();
    logic [12:0] a;
    case ($urandom_range(0, 5))
      0: a = 13'h0FFF;
      1: a = 13'h1000;
      2: a = 13'h1FFF;
      3: a = 13'h0000;
      4: a = 13'($urandom_range(0, 8191));
      default: a = 13'(32'h1000 + $urandom_range(0, 15));
    endcase
    return a;
  endfunction

  // One arbitration round: raise the requested ports together in an IDLE
  // cycle and check every bus output cycle by cycle until both are served.
  task automatic do_pair(input bit a_on, input logic a_we, input logic [12:0] a_ad, input logic [7:0] a_wd,
                         input bit b_on, input logic b_we, input logic [12:0] b_ad, input logic [7:0] b_wd);
    bit          on [2];
    logic        we [2];
    logic [12:0] ad [2];
    logic [7:0]  wd [2];
    int          s [2];
    logic [7:0]  erd [2];
    bit          eerr [2];
    bit          e_gnt [2];
    bit          e_ack [2];
    int          first, second, end_k, p;
    bit          e_rd, e_wr, e_rom, e_ram, e_err, any_win;
    logic [12:0] e_addr;
    on[0] = a_on; we[0] = a_we; ad[0] = a_ad; wd[0] = a_wd;
    on[1] = b_on; we[1] = b_we; ad[1] = b_ad; wd[1] = b_wd;
    erd[0] = '0; erd[1] = '0; eerr[0] = 0; eerr[1] = 0;
    if (a_on && b_on) first = last_a ? 1 : 0;
    else              first = a_on ? 0 : 1;
    second = 1 - first;
    s[first]  = 0;
    s[second] = 3 + WC;
    end_k = 0;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? first : second;
      if (on[p]) begin
        eerr[p] = we[p] && !ad[p][12];
        if (!we[p])        erd[p] = ad[p][12] ? ref_ram[ad[p][11:0]] : rom_byte(ad[p]);
        else if (ad[p][12]) ref_ram[ad[p][11:0]] = wd[p];
        last_a = (p == 0);
        end_k  = s[p] + 3 + WC;
      end
    end
    A_REQ = a_on; A_WE = a_we; A_ADDR = a_ad; A_WDATA = a_wd;
    B_REQ = b_on; B_WE = b_we; B_ADDR = b_ad; B_WDATA = b_wd;
    for (int k = 1; k <= end_k; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      e_rd = 0; e_wr = 0; e_rom = 0; e_ram = 0; e_err = 0; any_win = 0; e_addr = '0;
      for (int q = 0; q < 2; q++) begin
        e_gnt[q] = on[q] && (k >= s[q] + 1) && (k <= s[q] + 2 + WC);
        e_ack[q] = on[q] && (k == s[q] + 2 + WC);
        if (e_gnt[q]) begin
          any_win = 1;
          e_addr  = ad[q];
          e_rom  |= !ad[q][12];
          e_ram  |= ad[q][12];
        end
        if (on[q] && (k >= s[q] + 2) && (k <= s[q] + 1 + WC)) begin
          if (!we[q]) begin
            e_rd = 1;
            chk("rd_bus_data", DATA, erd[q]);
          end else if (ad[q][12]) begin
            e_wr = 1;
            chk("wr_bus_data", DATA, wd[q]);
          end else if (wd[q] != 8'h00 && wd[q] != 8'hFF) begin
            chk("rom_wr_bus_released", DATA === wd[q], 0);
          end
        end
        if (e_ack[q]) begin
          e_err |= eerr[q];
          if (!we[q]) hold = erd[q];
        end
      end
      chk("a_gnt", A_GNT, e_gnt[0]);
      chk("b_gnt", B_GNT, e_gnt[1]);
      chk("a_ack", A_ACK, e_ack[0]);
      chk("b_ack", B_ACK, e_ack[1]);
      chk("mem_rd", MEM_RD, e_rd);
      chk("mem_wr", MEM_WR, e_wr);
      chk("rom_en", ROM_EN, e_rom);
      chk("ram_en", RAM_EN, e_ram);
      chk("err", ERR, e_err);
      chk("rdata", RDATA, hold);
      if (any_win) chk("address", ADDRESS, e_addr);
      if (e_ack[0]) A_REQ = 0;
      if (e_ack[1]) B_REQ = 0;
    end
  endtask

  initial begin : main
    int          rd_cnt, ack_k;
    logic [7:0]  ack_rdata;
    logic        ack_err;
    bit          ra, rb;

    for (int i = 0; i < 4096; i++) ref_ram[i] = ram_init(13'(i));
    A_REQ = 0; A_WE = 0; A_ADDR = '0; A_WDATA = '0;
    B_REQ = 0; B_WE = 0; B_ADDR = '0; B_WDATA = '0;
    A_REQ3 = 0; A_WE3 = 0; A_ADDR3 = '0; A_WDATA3 = '0;
    B_REQ3 = 0; B_WE3 = 0; B_ADDR3 = '0; B_WDATA3 = '0;
    RST_N = 0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_a_gnt", A_GNT, 0);  chk("rst_b_gnt", B_GNT, 0);
    chk("rst_a_ack", A_ACK, 0);  chk("rst_b_ack", B_ACK, 0);
    chk("rst_rdata", RDATA, 0);  chk("rst_err", ERR, 0);
    chk("rst_address", ADDRESS, 0);
    chk("rst_rom_en", ROM_EN, 0); chk("rst_ram_en", RAM_EN, 0);
    chk("rst_mem_rd", MEM_RD, 0); chk("rst_mem_wr", MEM_WR, 0);
    chk("rst_a_gnt3", A_GNT3, 0); chk("rst_mem_rd3", MEM_RD3, 0);
    RST_N = 1;
    last_a = 0;
    hold   = 8'h00;
    @(negedge CLK);

    // ROM read by A
    do_pair(1, 0, 13'h0021, 8'h00, 0, 0, 13'h0000, 8'h00);
    // RAM write by A, then read back by B
    do_pair(1, 1, 13'h1002, 8'h55, 0, 0, 13'h0000, 8'h00);
    do_pair(0, 0, 13'h0000, 8'h00, 1, 0, 13'h1002, 8'h00);
    // Simultaneous reads alternate between ports
    for (int i = 0; i < 4; i++)
      do_pair(1, 0, 13'(32'h0100 + i), 8'h00, 1, 0, 13'(32'h1010 + i), 8'h00);
    // ROM write by B is rejected
    do_pair(0, 0, 13'h0000, 8'h00, 1, 1, 13'h0005, 8'hAA);

    // Longer access window on the WAIT_CYCLES=3 instance
    rd_cnt = 0; ack_k = 0; ack_rdata = '0; ack_err = 1'b1;
    A_REQ3 = 1; A_WE3 = 0; A_ADDR3 = 13'h1FFF;
    for (int k = 1; k <= 12; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (MEM_RD3) rd_cnt++;
      if (A_ACK3 && ack_k == 0) begin
        ack_k = k; ack_rdata = RDATA3; ack_err = ERR3;
        A_REQ3 = 0;
      end
      chk("w3_b_ack", B_ACK3, 0);
    end
    chk("w3_rd_cycles", rd_cnt, 3);
    chk("w3_ack_cycle", ack_k, 5);
    chk("w3_rdata", ack_rdata, ram_init(13'h1FFF));
    chk("w3_err", ack_err, 0);

    // Reset during the access phase of an A RAM write
    A_REQ = 1; A_WE = 1; A_ADDR = 13'h1100; A_WDATA = 8'h77;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("pre_rst_mem_wr", MEM_WR, 1);
    chk("pre_rst_data", DATA, 8'h77);
    #1 RST_N = 0;
    #1;
    chk("mid_rst_a_gnt", A_GNT, 0);   chk("mid_rst_a_ack", A_ACK, 0);
    chk("mid_rst_b_gnt", B_GNT, 0);   chk("mid_rst_b_ack", B_ACK, 0);
    chk("mid_rst_rdata", RDATA, 0);   chk("mid_rst_err", ERR, 0);
    chk("mid_rst_address", ADDRESS, 0);
    chk("mid_rst_rom_en", ROM_EN, 0); chk("mid_rst_ram_en", RAM_EN, 0);
    chk("mid_rst_mem_rd", MEM_RD, 0); chk("mid_rst_mem_wr", MEM_WR, 0);
    chk("mid_rst_data_released", DATA === 8'h77, 0);
    A_REQ = 0;
    @(negedge CLK);
    RST_N = 1;
    last_a = 0;
    hold   = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("post_rst_a_ack", A_ACK, 0);
      chk("post_rst_a_gnt", A_GNT, 0);
    end
    // First contest after reset goes to A; aborted write left RAM untouched
    do_pair(1, 0, 13'h1100, 8'h00, 1, 0, 13'h0FFF, 8'h00);

    // Random two-port traffic
    for (int n = 0; n < 40; n++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1;
      do_pair(ra, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom_range(0, 255)),
              rb, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
